// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, streams bytes from a 1-cycle synchronous RAM through a prefetch queue.
// Optional build macro FETCH_HALT_ON_ENDOP_EN stops fetching once ENDOP_OPCODE has been fetched.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DEPTH        = 4,
  parameter logic [7:0]  ENDOP_OPCODE = 8'd28
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [7:0]            imem_data,
  output logic [7:0]            ins,
  output logic                  ins_valid,
  input  logic                  ins_ready,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  halted,
  output logic [2:0]            q_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic {StRun, StHalt} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [7:0]            mem_q [DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [2:0]            count_q;
  logic                  inflight_q, kill_q;
  logic [7:0]            ins_q, ins_d;
  logic                  push, pop, halt_hit;

  // Data returning in a jump cycle, after a kill, or after ENDOP belongs to the old stream.
  assign push = inflight_q & ~kill_q & ~jump & (state_q == StRun);
  assign pop  = (count_q != 3'd0) & ins_ready & ~jump;

`ifdef FETCH_HALT_ON_ENDOP_EN
  assign halt_hit = push & (imem_data == ENDOP_OPCODE);
`else
  logic unused_endop;
  assign unused_endop = ^ENDOP_OPCODE;
  assign halt_hit     = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  // FSM next state; a jump always wins over a halt
  always_comb begin
    state_d = state_q;
    if (jump)          state_d = StRun;
    else if (halt_hit) state_d = StHalt;
  end

  // FSM outputs; counting the in-flight read keeps a push from ever finding the queue full
  always_comb begin
    halted  = (state_q == StHalt);
    imem_en = ~rst & (state_q == StRun) & ~jump &
              (({1'b0, count_q} + {3'b000, inflight_q}) < 4'(DEPTH));
  end

  assign imem_addr = pc_q;
  assign ins       = ins_q;
  assign ins_valid = (count_q != 3'd0);
  assign q_count   = count_q;

  // Next head value: keep the registered ins equal to the queue head, or hold it when empty.
  always_comb begin
    ins_d = ins_q;
    if (!jump) begin
      if ((count_q - 3'(pop)) != 3'd0) ins_d = mem_q[rd_ptr_q + PtrW'(pop)];
      else if (push)                   ins_d = imem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= imem_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      ins_q      <= '0;
    end else begin
      inflight_q <= imem_en;
      kill_q     <= jump;
      ins_q      <= ins_d;
      if (jump) begin
        pc_q     <= jump_addr;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (imem_en) pc_q <= pc_q + 1'b1;
        if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + 3'(push) - 3'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural 1-cycle synchronous RAM.
module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_en;
  logic [7:0] imem_addr;
  logic [7:0] imem_data = 8'd0;
  logic [7:0] ins;
  logic       ins_valid;
  logic       ins_ready = 1'b0;
  logic       jump = 1'b0;
  logic [7:0] jump_addr = 8'd0;
  logic       halted;
  logic [2:0] q_count;

  logic [7:0] ram [256];
  logic [7:0] got [8];
  int         n;
  int         nvec = 0;
  int         nerr = 0;

  instruction_fetch_unit #(.ADDR_WIDTH(8), .DEPTH(4), .ENDOP_OPCODE(8'd28)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_en   (imem_en),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .jump      (jump),
    .jump_addr (jump_addr),
    .halted    (halted),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_data <= ram[imem_addr];

  // Leaves the bench in cycle 1: first cycle after reset release, sampled 1 time unit in.
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1; jump = 1'b0; ins_ready = rdy;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Record up to 8 presented instructions over a fixed number of cycles (ins_ready assumed 1).
  task automatic collect(input int cycles);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      if (ins_valid) begin
        if (n < 8) got[n] = ins;
        n++;
      end
      step();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    nvec += 6;
    if (imem_en !== 1'b0)   begin nerr++; $display("FAIL reset_imem_en got %b want 0", imem_en); end
    if (imem_addr !== 8'd0) begin nerr++; $display("FAIL reset_addr got %h want 00", imem_addr); end
    if (ins_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", ins_valid); end
    if (ins !== 8'd0)       begin nerr++; $display("FAIL reset_ins got %h want 00", ins); end
    if (q_count !== 3'd0)   begin nerr++; $display("FAIL reset_count got %0d want 0", q_count); end
    if (halted !== 1'b0)    begin nerr++; $display("FAIL reset_halted got %b want 0", halted); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    nvec += 3;
    if (imem_en !== 1'b1)   begin nerr++; $display("FAIL stream_c1_en got %b want 1", imem_en); end
    if (imem_addr !== 8'd0) begin nerr++; $display("FAIL stream_c1_addr got %h want 00", imem_addr); end
    if (ins_valid !== 1'b0) begin nerr++; $display("FAIL stream_c1_valid got %b want 0", ins_valid); end
    step();
    nvec++;
    if (ins_valid !== 1'b0) begin nerr++; $display("FAIL stream_c2_valid got %b want 0", ins_valid); end
    for (int k = 1; k <= 6; k++) begin
      step();
      nvec++;
      if (ins_valid !== 1'b1 || ins !== 8'(k)) begin
        nerr++;
        $display("FAIL stream_c%0d got valid=%b ins=%h want valid=1 ins=%h", k + 2, ins_valid, ins,
                 8'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int c = 0; c < 7; c++) step();
    nvec += 3;
    if (q_count !== 3'd4)   begin nerr++; $display("FAIL bp_full_count got %0d want 4", q_count); end
    if (imem_en !== 1'b0)   begin nerr++; $display("FAIL bp_full_en got %b want 0", imem_en); end
    if (imem_addr !== 8'd4) begin nerr++; $display("FAIL bp_full_pc got %h want 04", imem_addr); end
    ins_ready = 1'b1;
    #1;
    collect(12);
    nvec++;
    if (n < 5) begin nerr++; $display("FAIL bp_drain_count got %0d want >=5", n); end
    for (int k = 0; k < 5; k++) begin
      nvec++;
      if (got[k] !== 8'(k + 1)) begin
        nerr++;
        $display("FAIL bp_order[%0d] got %h want %h", k, got[k], 8'(k + 1));
      end
    end
  endtask

  task automatic test_jump();
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) step();
    nvec++;
    if (q_count !== 3'd3) begin nerr++; $display("FAIL jump_pre_count got %0d want 3", q_count); end
    jump = 1'b1; jump_addr = 8'h40;
    #1;
    nvec++;
    if (imem_en !== 1'b0) begin nerr++; $display("FAIL jump_cycle_en got %b want 0", imem_en); end
    @(negedge clk);
    jump = 1'b0; ins_ready = 1'b1;
    #1;
    nvec += 3;
    if (q_count !== 3'd0)    begin nerr++; $display("FAIL jump_flush got %0d want 0", q_count); end
    if (imem_en !== 1'b1)    begin nerr++; $display("FAIL jump_refetch_en got %b want 1", imem_en); end
    if (imem_addr !== 8'h40) begin nerr++; $display("FAIL jump_addr got %h want 40", imem_addr); end
    collect(6);
    nvec += 2;
    if (got[0] !== 8'h41) begin nerr++; $display("FAIL jump_first got %h want 41", got[0]); end
    if (got[1] !== 8'h42) begin nerr++; $display("FAIL jump_second got %h want 42", got[1]); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    jump = 1'b1; jump_addr = 8'hFE;
    @(negedge clk);
    jump = 1'b0;
    #1;
    nvec++;
    if (imem_addr !== 8'hFE) begin nerr++; $display("FAIL wrap_fe got %h want fe", imem_addr); end
    step();
    nvec++;
    if (imem_addr !== 8'hFF) begin nerr++; $display("FAIL wrap_ff got %h want ff", imem_addr); end
    step();
    nvec++;
    if (imem_addr !== 8'h00) begin nerr++; $display("FAIL wrap_00 got %h want 00", imem_addr); end
    collect(4);
    nvec++;
    if (got[0] !== 8'hFF || got[1] !== 8'h00 || got[2] !== 8'h01) begin
      nerr++;
      $display("FAIL wrap_data got %h %h %h want ff 00 01", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_endop();
    ram[0] = 8'd7; ram[1] = 8'd28; ram[2] = 8'd9; ram[3] = 8'd10;
    do_reset(1'b1);
    collect(12);
    nvec += 2;
    if (got[0] !== 8'd7)  begin nerr++; $display("FAIL endop_w0 got %0d want 7", got[0]); end
    if (got[1] !== 8'd28) begin nerr++; $display("FAIL endop_w1 got %0d want 28", got[1]); end
`ifdef FETCH_HALT_ON_ENDOP_EN
    nvec += 3;
    if (n !== 2)          begin nerr++; $display("FAIL endop_count got %0d want 2", n); end
    if (halted !== 1'b1)  begin nerr++; $display("FAIL endop_halted got %b want 1", halted); end
    if (imem_en !== 1'b0) begin nerr++; $display("FAIL endop_en got %b want 0", imem_en); end
`else
    nvec += 3;
    if (n < 3)            begin nerr++; $display("FAIL endop_count got %0d want >=3", n); end
    if (got[2] !== 8'd9)  begin nerr++; $display("FAIL endop_w2 got %0d want 9", got[2]); end
    if (halted !== 1'b0)  begin nerr++; $display("FAIL endop_halted got %b want 0", halted); end
`endif
    @(negedge clk);
    jump = 1'b1; jump_addr = 8'h00;
    @(negedge clk);
    jump = 1'b0;
    #1;
    nvec++;
    if (halted !== 1'b0) begin nerr++; $display("FAIL endop_restart_halted got %b want 0", halted); end
    collect(8);
    nvec++;
    if (got[0] !== 8'd7 || got[1] !== 8'd28) begin
      nerr++;
      $display("FAIL endop_restart got %0d %0d want 7 28", got[0], got[1]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int c = 0; c < 3; c++) step();
    nvec++;
    if (q_count !== 3'd2) begin nerr++; $display("FAIL mid_pre_count got %0d want 2", q_count); end
    rst = 1'b1;
    #1;
    nvec += 4;
    if (ins_valid !== 1'b0) begin nerr++; $display("FAIL mid_valid got %b want 0", ins_valid); end
    if (imem_en !== 1'b0)   begin nerr++; $display("FAIL mid_en got %b want 0", imem_en); end
    if (q_count !== 3'd0)   begin nerr++; $display("FAIL mid_count got %0d want 0", q_count); end
    if (imem_addr !== 8'd0) begin nerr++; $display("FAIL mid_pc got %h want 00", imem_addr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i + 1);
    ram[27] = 8'hEE;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_wrap();
    test_reset_mid();
    test_endop();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
